// File: rtl/asic_iobank_pkg.sv
// Shared constants and helpers for the GPIO bank: legal pad implementations
// and the glitch-filter counter width.
package asic_iobank_pkg;

    localparam TYPE_SOFT = "SOFT";

    // Width of a counter that must reach f; never narrower than one bit.
    function automatic int cnt_width(input int f);
        return (f < 1) ? 1 : $clog2(f + 1);
    endfunction

endpackage

// File: rtl/asic_iobank_chan.sv
// One GPIO input channel: 2-flop synchroniser, optional glitch filter,
// edge detector and sticky interrupt status bit.
module asic_iobank_chan
    import asic_iobank_pkg::*;
#(
    parameter int FILTER = 0
) (
    input  logic clk,
    input  logic nreset,
    input  logic raw,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clr,
    output logic din,
    output logic status
);

    localparam int CW = cnt_width(FILTER);

    logic meta;
    logic sync;
    logic din_q;
    logic rise;
    logic fall;
    logic set;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    generate
        if (FILTER == 0) begin : g_bypass
            assign din = sync;
        end else begin : g_filter
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);
            logic [CW-1:0] cnt;
            logic          din_f;

            // din only follows sync once it has disagreed for FILTER
            // consecutive cycles; any agreement restarts the count.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    cnt   <= '0;
                    din_f <= 1'b0;
                end else if (sync == din_f) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    din_f <= sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign din = din_f;
        end
    endgenerate

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;
    assign set  = (rise & rise_en) | (fall & fall_en);

    // A new event in the same cycle as a clear keeps the status set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            din_q  <= 1'b0;
            status <= 1'b0;
        end else begin
            din_q  <= din;
            status <= (status & ~clr) | set;
        end
    end

endmodule

// File: rtl/asic_iobank.sv
// GPIO bank top: registered pad drivers with tristate, N independent input
// channels and the shared interrupt reduction.
module asic_iobank
    import asic_iobank_pkg::*;
#(
    parameter int N      = 8,
    parameter     TYPE   = "SOFT",
    parameter int FILTER = 0
) (
    input  logic         clk,
    input  logic         nreset,
    inout  wire  [N-1:0] pad,
    inout  wire          vddio,
    inout  wire          vssio,
    inout  wire          vdd,
    inout  wire          vss,
    inout  wire          poc,
    input  logic [N-1:0] dout,
    input  logic [N-1:0] oen,
    input  logic [N-1:0] ie,
    output logic [N-1:0] din,
    input  logic [N-1:0] irq_rise_en,
    input  logic [N-1:0] irq_fall_en,
    input  logic [N-1:0] irq_clr,
    output logic [N-1:0] irq_status,
    output logic         irq
);

    generate
        if (N < 1 || N > 64) begin : g_bad_n
            $error("asic_iobank: N must be in 1..64");
        end
        if (TYPE != TYPE_SOFT) begin : g_bad_type
            $error("asic_iobank: unsupported pad TYPE");
        end
        if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
            $error("asic_iobank: FILTER must be in 0..255");
        end
    endgenerate

    logic [N-1:0] dout_q;
    logic [N-1:0] oen_q;
    logic [N-1:0] raw;

    // Reset parks every pad in high-Z until the core drives oen low.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dout_q <= '0;
            oen_q  <= '1;
        end else begin
            dout_q <= dout;
            oen_q  <= oen;
        end
    end

    assign raw = pad & ie;

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            assign pad[i] = oen_q[i] ? 1'bz : dout_q[i];

            asic_iobank_chan #(
                .FILTER (FILTER)
            ) u_chan (
                .clk     (clk),
                .nreset  (nreset),
                .raw     (raw[i]),
                .rise_en (irq_rise_en[i]),
                .fall_en (irq_fall_en[i]),
                .clr     (irq_clr[i]),
                .din     (din[i]),
                .status  (irq_status[i])
            );
        end
    endgenerate

    assign irq = |irq_status;

endmodule

// File: tb/tb_asic_iobank.sv
// Directed bench for asic_iobank: one bypass instance and one FILTER=4
// instance share the core inputs and see the same pad stimulus.
module tb_asic_iobank;

    logic       clk;
    logic       nreset;
    logic [7:0] dout, oen, ie, rise_en, fall_en, irq_clr;
    logic [7:0] tb_oe, tb_val;
    wire  [7:0] pad0, pad4;
    wire        vddio, vssio, vdd, vss, poc;
    logic [7:0] din0, din4, st0, st4;
    logic       irq0, irq4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] pad;
        logic [7:0] ie;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] clr;
        logic [7:0] edin;
        logic [7:0] est;
    } vec_t;

    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_drv
            assign pad0[i] = tb_oe[i] ? tb_val[i] : 1'bz;
            assign pad4[i] = tb_oe[i] ? tb_val[i] : 1'bz;
        end
    endgenerate

    asic_iobank #(.N(8), .TYPE("SOFT"), .FILTER(0)) dut0 (
        .clk(clk), .nreset(nreset), .pad(pad0),
        .vddio(vddio), .vssio(vssio), .vdd(vdd), .vss(vss), .poc(poc),
        .dout(dout), .oen(oen), .ie(ie), .din(din0),
        .irq_rise_en(rise_en), .irq_fall_en(fall_en), .irq_clr(irq_clr),
        .irq_status(st0), .irq(irq0)
    );

    asic_iobank #(.N(8), .TYPE("SOFT"), .FILTER(4)) dut4 (
        .clk(clk), .nreset(nreset), .pad(pad4),
        .vddio(vddio), .vssio(vssio), .vdd(vdd), .vss(vss), .poc(poc),
        .dout(dout), .oen(oen), .ie(ie), .din(din4),
        .irq_rise_en(rise_en), .irq_fall_en(fall_en), .irq_clr(irq_clr),
        .irq_status(st4), .irq(irq4)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        tb_val  = v.pad;
        ie      = v.ie;
        rise_en = v.rise;
        fall_en = v.fall;
        irq_clr = v.clr;
    endtask

    task automatic clearAll();
        rise_en = 8'h00;
        fall_en = 8'h00;
        irq_clr = 8'hFF;
        tick();
        irq_clr = 8'h00;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_hiz0"}, dut0.oen_q, 8'hFF);
        checkOutput({tag, "_hiz4"}, dut4.oen_q, 8'hFF);
        checkOutput({tag, "_din0"}, din0, 8'h00);
        checkOutput({tag, "_din4"}, din4, 8'h00);
        checkOutput({tag, "_st0"}, st0, 8'h00);
        checkOutput({tag, "_st4"}, st4, 8'h00);
        checkOutput({tag, "_irq0"}, irq0, 1'b0);
        checkOutput({tag, "_irq4"}, irq4, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h0F};
        vecs[2] = '{8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h0F};
        vecs[3] = '{8'hFF, 8'hFF, 8'h30, 8'h00, 8'h00, 8'hFF, 8'h3F};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[5] = '{8'hA5, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hA5, 8'h5A};
        vecs[6] = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h05, 8'h5A};
        vecs[7] = '{8'h05, 8'hFF, 8'h00, 8'h00, 8'h0A, 8'h05, 8'h50};
        vecs[8] = '{8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h51};

        // Reset with every core input active.
        nreset  = 1'b0;
        dout    = 8'hFF;
        oen     = 8'h00;
        ie      = 8'hFF;
        rise_en = 8'hFF;
        fall_en = 8'hFF;
        irq_clr = 8'h00;
        tb_oe   = 8'h00;
        tb_val  = 8'h00;
        tick(3);
        checkResetState("reset");

        nreset = 1'b1;
        oen    = 8'hFE;
        dout   = 8'h01;
        rise_en = 8'h00;
        fall_en = 8'h00;
        tick();
        checkOutput("pad0_drive_f0", pad0[0], 1'b1);
        checkOutput("pad0_drive_f4", pad4[0], 1'b1);
        checkOutput("release_nostat", st0, 8'h00);
        oen  = 8'hFF;
        dout = 8'h00;
        tick();
        tb_oe  = 8'hFF;
        tb_val = 8'h00;
        tick(2);

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v]);
            tick(8);
            checkOutput($sformatf("vec%0d_din0", v), din0, vecs[v].edin);
            checkOutput($sformatf("vec%0d_din4", v), din4, vecs[v].edin);
            checkOutput($sformatf("vec%0d_st0", v), st0, vecs[v].est);
            checkOutput($sformatf("vec%0d_st4", v), st4, vecs[v].est);
            checkOutput($sformatf("vec%0d_irq0", v), irq0, |vecs[v].est);
        end
        clearAll();

        // Rising edge latency on channel 3 of the bypass instance.
        ie      = 8'hFF;
        tb_val  = 8'h00;
        rise_en = 8'h08;
        tick(4);
        clearAll();
        rise_en = 8'h08;
        tb_val[3] = 1'b1;
        tick();
        checkOutput("ch3_din_e1", din0[3], 1'b0);
        tick();
        checkOutput("ch3_din_e2", din0[3], 1'b1);
        checkOutput("ch3_st_e2", st0[3], 1'b0);
        tick();
        checkOutput("ch3_st_e3", st0[3], 1'b1);
        checkOutput("ch3_irq_e3", irq0, 1'b1);
        tick(8);
        clearAll();

        // Set and clear in the same cycle on channel 5.
        rise_en = 8'h20;
        tb_val[5] = 1'b1;
        tick(2);
        irq_clr = 8'h20;
        tick();
        checkOutput("ch5_setwins", st0[5], 1'b1);
        tick();
        checkOutput("ch5_cleared", st0[5], 1'b0);
        checkOutput("ch5_irq_low", irq0, 1'b0);
        irq_clr = 8'h00;
        tick(8);
        clearAll();

        // Dropping ie produces a legitimate falling edge on channel 1.
        tb_val[1] = 1'b1;
        tick(4);
        checkOutput("ch1_high", din0[1], 1'b1);
        fall_en = 8'h02;
        ie[1]   = 1'b0;
        tick(2);
        checkOutput("ch1_ie_fall", din0[1], 1'b0);
        tick();
        checkOutput("ch1_fall_st", st0[1], 1'b1);
        checkOutput("ch1_fall_irq", irq0, 1'b1);
        tick(8);
        clearAll();

        // Filtered instance: a 3-cycle pulse is swallowed.
        begin
            logic seen;
            seen = 1'b0;
            tb_val[2] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                seen = seen | din4[2];
            end
            tb_val[2] = 1'b0;
            for (int k = 0; k < 12; k++) begin
                tick();
                seen = seen | din4[2];
            end
            checkOutput("f4_short_pulse_din", seen, 1'b0);
            checkOutput("f4_short_pulse_st", st4, 8'h00);
        end

        // A 6-cycle pulse passes, 4 edges after sync.
        tb_val[2] = 1'b1;
        tick(2);
        checkOutput("f0_pulse_din_e2", din0[2], 1'b1);
        tick(3);
        checkOutput("f4_pulse_din_e5", din4[2], 1'b0);
        tick();
        checkOutput("f4_pulse_din_e6", din4[2], 1'b1);
        tb_val[2] = 1'b0;
        tick(10);
        checkOutput("f4_pulse_din_back", din4[2], 1'b0);
        clearAll();

        // Reset mid-filter, then full latency after release.
        tb_val[6] = 1'b1;
        tick(4);
        #2;
        nreset = 1'b0;
        #1;
        checkResetState("midreset");
        tick();
        nreset = 1'b1;
        tick();
        checkOutput("rel_nostat0", st0, 8'h00);
        checkOutput("rel_nostat4", st4, 8'h00);
        tick(4);
        checkOutput("rel_f4_din_e5", din4[6], 1'b0);
        tick();
        checkOutput("rel_f4_din_e6", din4[6], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
